spi_reg_slave: RTL and testbench

Parametrised SPI target with an addressed register file, run entirely in the system clock domain. It replaces the single SCK-clocked shift register: SCK, MOSI and CS_N are synchronised and edge-detected, all four SPI modes are selectable, and frames carry a command word followed by an auto-incrementing burst. It sits between the host SPI pins and on-board LED/control logic, and one read-only register snapshots a status input.

---
 rtl/spi_reg_slave.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI target with an addressed register file, run entirely in the clk domain.
// A frame is a command word (R/W + start address) followed by an auto-incrementing data burst.
module spi_reg_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sck,
  input  logic                              mosi,
  input  logic                              cs_n,
  output logic                              miso,
  input  logic [DATA_W-1:0]                 status_in,
  output logic [(2**ADDR_W)*DATA_W-1:0]     reg_out,
  output logic                              wr_strobe,
  output logic [ADDR_W-1:0]                 wr_addr,
  output logic                              active
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NREG - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_W - 1);
  localparam bit                SAMPLE_RISE = (CPOL == CPHA);
  localparam bit                EARLY_FIRST = (CPHA == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t state_r, state_nx_s;

  logic [2:0]        sck_sync_r;
  logic [1:0]        mosi_sync_r;
  logic [2:0]        cs_sync_r;

  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-2:0] shift_in_r;
  logic [DATA_W-1:0] shift_out_r;
  logic [ADDR_W-1:0] addr_r;
  logic              rw_r;
  logic [DATA_W-1:0] snap_r;
  logic [DATA_W-1:0] regs_r [NREG];
  logic              miso_r;
  logic              wr_strobe_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic              active_r;

  logic              sck_rise_s, sck_fall_s, sample_s, shift_s;
  logic              cs_fall_s, cs_rise_s, mosi_s;
  logic              word_done_s, cmd_done_s, data_done_s, wr_en_s;
  logic [DATA_W-1:0] word_s;
  logic [ADDR_W-1:0] cmd_addr_s, addr_inc_s;
  logic [DATA_W-1:0] rd_cmd_s, rd_next_s;

  // Two-stage synchronisers; the third sck/cs_n stage is the previous value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_r  <= 3'b000;
      mosi_sync_r <= 2'b00;
      cs_sync_r   <= 3'b000;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], sck};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      cs_sync_r   <= {cs_sync_r[1:0], cs_n};
    end
  end

  assign sck_rise_s  = sck_sync_r[1] & ~sck_sync_r[2];
  assign sck_fall_s  = ~sck_sync_r[1] & sck_sync_r[2];
  assign sample_s    = SAMPLE_RISE ? sck_rise_s : sck_fall_s;
  assign shift_s     = SAMPLE_RISE ? sck_fall_s : sck_rise_s;
  assign cs_fall_s   = ~cs_sync_r[1] & cs_sync_r[2];
  assign cs_rise_s   = cs_sync_r[1] & ~cs_sync_r[2];
  assign mosi_s      = mosi_sync_r[1];

  // A word completing on the same cycle as a cs_n rise is treated as aborted.
  assign word_s      = {shift_in_r, mosi_s};
  assign word_done_s = sample_s && (bit_cnt_r == LAST_BIT) && !cs_rise_s;
  assign cmd_done_s  = word_done_s && (state_r == ST_CMD);
  assign data_done_s = word_done_s && (state_r == ST_DATA);
  assign wr_en_s     = data_done_s && !rw_r && (addr_r != LAST_ADDR);
  assign cmd_addr_s  = word_s[ADDR_W-1:0];
  assign addr_inc_s  = addr_r + ADDR_W'(1);

  // Read map: the top address returns the frame-start status snapshot.
  always_comb begin
    rd_cmd_s  = regs_r[cmd_addr_s];
    rd_next_s = regs_r[addr_inc_s];
    if (cmd_addr_s == LAST_ADDR) begin
      rd_cmd_s = snap_r;
    end else begin
      rd_cmd_s = regs_r[cmd_addr_s];
    end
    if (addr_inc_s == LAST_ADDR) begin
      rd_next_s = snap_r;
    end else begin
      rd_next_s = regs_r[addr_inc_s];
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: cs_n rise returns to IDLE from anywhere.
  always_comb begin
    state_nx_s = state_r;
    if (cs_rise_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_nx_s = ST_CMD;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (cmd_done_s) begin
            state_nx_s = ST_DATA;
          end else begin
            state_nx_s = ST_CMD;
          end
        end
        ST_DATA: state_nx_s = ST_DATA;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Bit counter, shift registers, address pointer and status snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r   <= '0;
      shift_in_r  <= '0;
      shift_out_r <= '0;
      addr_r      <= '0;
      rw_r        <= 1'b0;
      snap_r      <= '0;
    end else if (cs_rise_s) begin
      bit_cnt_r   <= '0;
      shift_in_r  <= '0;
      shift_out_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r  <= '0;
          shift_in_r <= '0;
          if (cs_fall_s) begin
            snap_r <= status_in;
          end
        end
        ST_CMD, ST_DATA: begin
          if (sample_s) begin
            shift_in_r <= word_s[DATA_W-2:0];
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= '0;
              if (state_r == ST_CMD) begin
                rw_r        <= word_s[DATA_W-1];
                addr_r      <= cmd_addr_s;
                shift_out_r <= rd_cmd_s;
              end else begin
                addr_r      <= addr_inc_s;
                shift_out_r <= rd_next_s;
              end
            end else begin
              bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
              shift_out_r <= {shift_out_r[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: begin
          bit_cnt_r  <= '0;
          shift_in_r <= '0;
        end
      endcase
    end
  end

  // Register file with its write-commit strobe; the top address is read-only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        regs_r[k] <= '0;
      end
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= '0;
    end else begin
      wr_strobe_r <= wr_en_s;
      if (wr_en_s) begin
        regs_r[addr_r] <= word_s;
        wr_addr_r      <= addr_r;
      end
    end
  end

  // MISO: with CPHA=0 the first data bit appears as the command completes, else on shift edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_r <= 1'b0;
    end else if (cs_rise_s) begin
      miso_r <= 1'b0;
    end else if (state_r == ST_CMD) begin
      if (cmd_done_s && EARLY_FIRST && word_s[DATA_W-1]) begin
        miso_r <= rd_cmd_s[DATA_W-1];
      end else begin
        miso_r <= 1'b0;
      end
    end else if ((state_r == ST_DATA) && rw_r) begin
      if (shift_s) begin
        miso_r <= shift_out_r[DATA_W-1];
      end
    end else begin
      miso_r <= 1'b0;
    end
  end

  // Frame-active flag tracks the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
    end else begin
      active_r <= (state_nx_s != ST_IDLE);
    end
  end

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NREG; k++) begin
      reg_out[k*DATA_W +: DATA_W] = regs_r[k];
    end
  end

  assign miso      = miso_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign active    = active_r;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: a mode-0 8-bit/8-register instance and a mode-3 16-bit/4-register instance.
`timescale 1ns/1ps
module tb_spi_reg_slave;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        sck0, mosi0, cs0_n, miso0;
  logic [7:0]  status0;
  logic [63:0] reg_out0;
  logic        wr_strobe0;
  logic [2:0]  wr_addr0;
  logic        active0;

  logic        sck3, mosi3, cs3_n, miso3;
  logic [15:0] status3;
  logic [63:0] reg_out3;
  logic        wr_strobe3;
  logic [1:0]  wr_addr3;
  logic        active3;

  int checks = 0;
  int errors = 0;
  int strobe_cnt0 = 0;
  int strobe_cnt3 = 0;
  int miso_hi0 = 0;
  logic [2:0] strobe_log0 [0:63];

  spi_reg_slave #(.DATA_W(8), .ADDR_W(3), .CPOL(0), .CPHA(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck0), .mosi(mosi0), .cs_n(cs0_n), .miso(miso0),
    .status_in(status0), .reg_out(reg_out0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0),
    .active(active0)
  );

  spi_reg_slave #(.DATA_W(16), .ADDR_W(2), .CPOL(1), .CPHA(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .sck(sck3), .mosi(mosi3), .cs_n(cs3_n), .miso(miso3),
    .status_in(status3), .reg_out(reg_out3), .wr_strobe(wr_strobe3), .wr_addr(wr_addr3),
    .active(active3)
  );

  always #5 clk = ~clk;

  // Log committed writes and count cycles with miso high on the 8-bit instance.
  always @(negedge clk) begin
    if (wr_strobe0 === 1'b1) begin
      strobe_log0[strobe_cnt0[5:0]] <= wr_addr0;
      strobe_cnt0 <= strobe_cnt0 + 1;
    end
    if (wr_strobe3 === 1'b1) strobe_cnt3 <= strobe_cnt3 + 1;
    if (miso0 === 1'b1) miso_hi0 <= miso_hi0 + 1;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame0_begin();
    cs0_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame0_end();
    repeat (HALF) @(negedge clk);
    cs0_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Mode 0: drive while SCK is low, both sides sample on the rising edge.
  task automatic xfer0(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi0 = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx[7-i] = miso0;
      sck0 = 1'b1;
      repeat (HALF) @(negedge clk);
      sck0 = 1'b0;
    end
  endtask

  task automatic write0(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] rx;
    frame0_begin();
    xfer0(cmd, 8, rx);
    xfer0(data, 8, rx);
    frame0_end();
  endtask

  // Mode 3: SCK idles high, data changes after the falling edge, sampled on the rising edge.
  task automatic xfer3(input logic [15:0] tx, output logic [15:0] rx);
    rx = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      sck3 = 1'b0;
      mosi3 = tx[15-i];
      repeat (HALF) @(negedge clk);
      rx[15-i] = miso3;
      sck3 = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (reg_out0 !== 64'h0) begin errors++; $display("FAIL reset_reg_out0: got %h expected %h", reg_out0, 64'h0); end
    checks++; if ({miso0, wr_strobe0, wr_addr0, active0} !== 6'b0) begin errors++; $display("FAIL reset_outs0: got %b expected %b", {miso0, wr_strobe0, wr_addr0, active0}, 6'b0); end
    checks++; if (reg_out3 !== 64'h0) begin errors++; $display("FAIL reset_reg_out3: got %h expected %h", reg_out3, 64'h0); end
    checks++; if ({miso3, wr_strobe3, wr_addr3, active3} !== 5'b0) begin errors++; $display("FAIL reset_outs3: got %b expected %b", {miso3, wr_strobe3, wr_addr3, active3}, 5'b0); end
  endtask

  task automatic test_single_write();
    int s0, m0;
    logic [7:0] rx;
    logic act;
    do_reset();
    s0 = strobe_cnt0;
    m0 = miso_hi0;
    frame0_begin();
    xfer0(8'h02, 8, rx);
    act = active0;
    xfer0(8'hA5, 8, rx);
    frame0_end();
    checks++; if (reg_out0[23:16] !== 8'hA5) begin errors++; $display("FAIL single_reg2: got %h expected %h", reg_out0[23:16], 8'hA5); end
    checks++; if (strobe_cnt0 - s0 !== 1) begin errors++; $display("FAIL single_strobes: got %0d expected %0d", strobe_cnt0 - s0, 1); end
    checks++; if (strobe_log0[s0[5:0]] !== 3'd2) begin errors++; $display("FAIL single_wr_addr: got %0d expected %0d", strobe_log0[s0[5:0]], 2); end
    checks++; if (miso_hi0 - m0 !== 0) begin errors++; $display("FAIL single_miso_zero: got %0d high cycles expected %0d", miso_hi0 - m0, 0); end
    checks++; if (act !== 1'b1) begin errors++; $display("FAIL single_active_mid: got %b expected %b", act, 1'b1); end
    checks++; if (active0 !== 1'b0) begin errors++; $display("FAIL single_active_end: got %b expected %b", active0, 1'b0); end
  endtask

  task automatic test_burst_wrap();
    int s0, s1;
    logic [7:0] rx;
    do_reset();
    s0 = strobe_cnt0;
    s1 = s0 + 1;
    frame0_begin();
    xfer0(8'h06, 8, rx);
    xfer0(8'h11, 8, rx);
    xfer0(8'h22, 8, rx);
    xfer0(8'h33, 8, rx);
    frame0_end();
    checks++; if (reg_out0[55:48] !== 8'h11) begin errors++; $display("FAIL burst_reg6: got %h expected %h", reg_out0[55:48], 8'h11); end
    checks++; if (reg_out0[63:56] !== 8'h00) begin errors++; $display("FAIL burst_reg7: got %h expected %h", reg_out0[63:56], 8'h00); end
    checks++; if (reg_out0[7:0] !== 8'h33) begin errors++; $display("FAIL burst_reg0: got %h expected %h", reg_out0[7:0], 8'h33); end
    checks++; if (strobe_cnt0 - s0 !== 2) begin errors++; $display("FAIL burst_strobes: got %0d expected %0d", strobe_cnt0 - s0, 2); end
    checks++; if (strobe_log0[s0[5:0]] !== 3'd6) begin errors++; $display("FAIL burst_addr_first: got %0d expected %0d", strobe_log0[s0[5:0]], 6); end
    checks++; if (strobe_log0[s1[5:0]] !== 3'd0) begin errors++; $display("FAIL burst_addr_second: got %0d expected %0d", strobe_log0[s1[5:0]], 0); end
  endtask

  task automatic test_read_snapshot();
    int s0;
    logic [7:0] rx, rd_a, rd_b, rd_c;
    do_reset();
    write0(8'h01, 8'h3C);
    s0 = strobe_cnt0;
    status0 = 8'h81;
    frame0_begin();
    xfer0(8'h81, 8, rx);
    status0 = 8'h00;
    xfer0(8'h00, 8, rd_a);
    xfer0(8'h00, 8, rd_b);
    frame0_end();
    status0 = 8'h81;
    frame0_begin();
    xfer0(8'h87, 8, rx);
    status0 = 8'h00;
    xfer0(8'h00, 8, rd_c);
    frame0_end();
    checks++; if (rd_a !== 8'h3C) begin errors++; $display("FAIL read_reg1: got %h expected %h", rd_a, 8'h3C); end
    checks++; if (rd_b !== 8'h00) begin errors++; $display("FAIL read_reg2: got %h expected %h", rd_b, 8'h00); end
    checks++; if (rd_c !== 8'h81) begin errors++; $display("FAIL read_snapshot: got %h expected %h", rd_c, 8'h81); end
    checks++; if (strobe_cnt0 - s0 !== 0) begin errors++; $display("FAIL read_no_strobe: got %0d expected %0d", strobe_cnt0 - s0, 0); end
  endtask

  task automatic test_abort();
    int s0;
    logic [7:0] rx;
    do_reset();
    write0(8'h03, 8'hC3);
    s0 = strobe_cnt0;
    frame0_begin();
    xfer0(8'h03, 8, rx);
    xfer0(8'hFF, 5, rx);
    frame0_end();
    checks++; if (reg_out0[31:24] !== 8'hC3) begin errors++; $display("FAIL abort_reg3: got %h expected %h", reg_out0[31:24], 8'hC3); end
    checks++; if (strobe_cnt0 - s0 !== 0) begin errors++; $display("FAIL abort_no_strobe: got %0d expected %0d", strobe_cnt0 - s0, 0); end
    s0 = strobe_cnt0;
    write0(8'h03, 8'h5A);
    checks++; if (reg_out0[31:24] !== 8'h5A) begin errors++; $display("FAIL abort_retry_reg3: got %h expected %h", reg_out0[31:24], 8'h5A); end
    checks++; if (strobe_cnt0 - s0 !== 1) begin errors++; $display("FAIL abort_retry_strobes: got %0d expected %0d", strobe_cnt0 - s0, 1); end
    checks++; if (strobe_log0[s0[5:0]] !== 3'd3) begin errors++; $display("FAIL abort_retry_addr: got %0d expected %0d", strobe_log0[s0[5:0]], 3); end
  endtask

  task automatic test_mode3_wide();
    int s3;
    logic [15:0] rx;
    do_reset();
    s3 = strobe_cnt3;
    cs3_n = 1'b0;
    repeat (8) @(negedge clk);
    xfer3(16'h0001, rx);
    xfer3(16'hBEEF, rx);
    repeat (HALF) @(negedge clk);
    cs3_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (reg_out3[31:16] !== 16'hBEEF) begin errors++; $display("FAIL mode3_reg1: got %h expected %h", reg_out3[31:16], 16'hBEEF); end
    checks++; if (reg_out3[15:0] !== 16'h0000) begin errors++; $display("FAIL mode3_reg0: got %h expected %h", reg_out3[15:0], 16'h0000); end
    checks++; if (wr_addr3 !== 2'd1) begin errors++; $display("FAIL mode3_wr_addr: got %0d expected %0d", wr_addr3, 1); end
    checks++; if (strobe_cnt3 - s3 !== 1) begin errors++; $display("FAIL mode3_strobes: got %0d expected %0d", strobe_cnt3 - s3, 1); end
    cs3_n = 1'b0;
    repeat (8) @(negedge clk);
    xfer3(16'h8001, rx);
    xfer3(16'h0000, rx);
    repeat (HALF) @(negedge clk);
    cs3_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (rx !== 16'hBEEF) begin errors++; $display("FAIL mode3_readback: got %h expected %h", rx, 16'hBEEF); end
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    logic [7:0] rx;
    logic act, pre_miso;
    do_reset();
    write0(8'h05, 8'h7F);
    frame0_begin();
    xfer0(8'h85, 8, rx);
    xfer0(8'h00, 4, rx);
    act = active0;
    pre_miso = miso0;
    rst_n = 1'b0;
    #1;
    checks++; if (act !== 1'b1 || pre_miso !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got active %b miso %b expected 1 1", act, pre_miso); end
    checks++; if (reg_out0 !== 64'h0) begin errors++; $display("FAIL rstmid_reg_out: got %h expected %h", reg_out0, 64'h0); end
    checks++; if ({miso0, wr_strobe0, wr_addr0, active0} !== 6'b0) begin errors++; $display("FAIL rstmid_outs: got %b expected %b", {miso0, wr_strobe0, wr_addr0, active0}, 6'b0); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    s0 = strobe_cnt0;
    xfer0(8'h02, 8, rx);
    xfer0(8'hAA, 8, rx);
    xfer0(8'h55, 8, rx);
    repeat (4) @(negedge clk);
    checks++; if (strobe_cnt0 - s0 !== 0) begin errors++; $display("FAIL rstmid_no_strobe: got %0d expected %0d", strobe_cnt0 - s0, 0); end
    checks++; if (reg_out0 !== 64'h0) begin errors++; $display("FAIL rstmid_regs_after: got %h expected %h", reg_out0, 64'h0); end
    checks++; if (active0 !== 1'b0) begin errors++; $display("FAIL rstmid_active_after: got %b expected %b", active0, 1'b0); end
    frame0_end();
  endtask

  initial begin
    rst_n   = 1'b1;
    sck0    = 1'b0;
    mosi0   = 1'b0;
    cs0_n   = 1'b1;
    status0 = 8'h00;
    sck3    = 1'b1;
    mosi3   = 1'b0;
    cs3_n   = 1'b1;
    status3 = 16'h0000;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_read_snapshot();
    test_abort();
    test_mode3_wide();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
